entry_ctrl: RTL and testbench

//   User-input front end producing the values shown on the 8-digit display:

---
 rtl/entry_ctrl_if.sv | 34 +++
 rtl/entry_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_entry_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/entry_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : entry_ctrl_if
//  Purpose  : Bundles the push-button inputs and the display-facing outputs
//             of the entry controller.
//  Signals  : btn_c/btn_u/btn_d  raw centre/up/down buttons
//             prog[2:0], modulee[1:0], data_2[15:0]  entered values
//             field[2:0]  field currently being edited (FSM state)
//             start       one-cycle commit pulse
//  Modports : master - button source / display consumer
//             slave  - entry controller
//  Revision : 1.0  initial release
// ============================================================================
interface entry_ctrl_if;
  logic        btn_c;
  logic        btn_u;
  logic        btn_d;
  logic [2:0]  prog;
  logic [1:0]  modulee;
  logic [15:0] data_2;
  logic [2:0]  field;
  logic        start;

  modport master (
    output btn_c, btn_u, btn_d,
    input  prog, modulee, data_2, field, start
  );

  modport slave (
    input  btn_c, btn_u, btn_d,
    output prog, modulee, data_2, field, start
  );
endinterface
`default_nettype wire

// File: rtl/entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : entry_ctrl
//  Purpose  : User-input front end. Synchronises and debounces three push
//             buttons, turns accepted presses into single-cycle pulses and
//             walks a field-edit state machine that produces the program,
//             module and 16-bit operand shown on the display. Emits a
//             one-cycle start pulse when the entry is committed.
//  Ports    : clk   system clock
//             rst   asynchronous active-high reset
//             bus   entry_ctrl_if.slave (buttons in, display values out)
//  Params   : DB_CYCLES  stable cycles needed to accept a new button level
//             DB_W       debounce counter width, 2**DB_W > DB_CYCLES
//  Revision : 1.0  initial release
// ============================================================================
module entry_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  wire logic   clk,
  input  wire logic   rst,
  entry_ctrl_if.slave bus
);

  localparam int              c_NBTN    = 3;
  localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);

  // Button indices into the raw / press vectors
  localparam int c_BTN_C = 0;
  localparam int c_BTN_U = 1;
  localparam int c_BTN_D = 2;

  typedef enum logic [2:0] {
    S_PROG = 3'd0,
    S_MOD  = 3'd1,
    S_D0   = 3'd2,
    S_D1   = 3'd3,
    S_D2   = 3'd4,
    S_D3   = 3'd5,
    S_RUN  = 3'd6
  } state_t;

  logic [c_NBTN-1:0] w_raw;
  logic [c_NBTN-1:0] w_press;

  assign w_raw = {bus.btn_d, bus.btn_u, bus.btn_c};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and press-edge detector
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_btn
      logic            r_sync0;
      logic            r_sync1;
      logic            r_acc;    // accepted (debounced) level
      logic            r_acc_q;  // accepted level, one cycle late
      logic            r_press;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync0 <= 1'b0;
          r_sync1 <= 1'b0;
          r_acc   <= 1'b0;
          r_acc_q <= 1'b0;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync0 <= w_raw[gi];
          r_sync1 <= r_sync0;

          // The counter only advances while the synced level disagrees with
          // the accepted one; any bounce back to agreement restarts it.
          if (r_sync1 == r_acc) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_acc <= ~r_acc;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end

          // Rising edge of the accepted level only: a held button never repeats.
          r_acc_q <= r_acc;
          r_press <= r_acc & ~r_acc_q;
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Edit decode
  // --------------------------------------------------------------------------
  logic        w_press_c;
  logic        w_step_up;
  logic        w_step_dn;
  logic [1:0]  w_nib_idx;
  logic [3:0]  w_nib_cur;

  assign w_press_c = w_press[c_BTN_C];

  // A centre press takes priority over any edit; up+down together cancel.
  assign w_step_up = w_press[c_BTN_U] & ~w_press[c_BTN_D] & ~w_press_c;
  assign w_step_dn = w_press[c_BTN_D] & ~w_press[c_BTN_U] & ~w_press_c;

  state_t      r_state;
  logic [2:0]  r_prog;
  logic [1:0]  r_mod;
  logic [15:0] r_data;
  logic        r_start;

  always_comb begin
    w_nib_idx = 2'd0;
    case (r_state)
      S_D0:    w_nib_idx = 2'd0;
      S_D1:    w_nib_idx = 2'd1;
      S_D2:    w_nib_idx = 2'd2;
      S_D3:    w_nib_idx = 2'd3;
      default: w_nib_idx = 2'd0;
    endcase
  end

  assign w_nib_cur = r_data[{w_nib_idx, 2'b00} +: 4];

  // --------------------------------------------------------------------------
  // Field-edit state machine with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_PROG;
      r_prog  <= 3'd0;
      r_mod   <= 2'd0;
      r_data  <= 16'd0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;

      if (w_press_c) begin
        case (r_state)
          S_PROG:  r_state <= S_MOD;
          S_MOD:   r_state <= S_D0;
          S_D0:    r_state <= S_D1;
          S_D1:    r_state <= S_D2;
          S_D2:    r_state <= S_D3;
          S_D3: begin
            // start rises together with the first cycle spent in S_RUN
            r_state <= S_RUN;
            r_start <= 1'b1;
          end
          S_RUN:   r_state <= S_PROG;   // entered values are kept
          default: r_state <= S_PROG;
        endcase
      end else begin
        case (r_state)
          S_PROG: begin
            if (w_step_up)      r_prog <= r_prog + 3'd1;
            else if (w_step_dn) r_prog <= r_prog - 3'd1;
          end
          S_MOD: begin
            if (w_step_up)      r_mod <= r_mod + 2'd1;
            else if (w_step_dn) r_mod <= r_mod - 2'd1;
          end
          S_D0, S_D1, S_D2, S_D3: begin
            if (w_step_up)      r_data[{w_nib_idx, 2'b00} +: 4] <= w_nib_cur + 4'd1;
            else if (w_step_dn) r_data[{w_nib_idx, 2'b00} +: 4] <= w_nib_cur - 4'd1;
          end
          S_RUN: begin
            // values frozen while running
          end
          default: r_state <= S_PROG;   // unused encoding 7 recovers
        endcase
      end
    end
  end

  assign bus.prog    = r_prog;
  assign bus.modulee = r_mod;
  assign bus.data_2  = r_data;
  assign bus.field   = r_state;
  assign bus.start   = r_start;

endmodule
`default_nettype wire

// File: tb/tb_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entry_ctrl
//  Purpose  : Self-checking bench for entry_ctrl with DB_CYCLES=4. Stimulus
//             pushes hand-computed output snapshots into a queue; a monitor
//             compares each observed output change against the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_entry_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  entry_ctrl_if bus ();

  entry_ctrl #(
    .DB_CYCLES(4),
    .DB_W     (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          start_cnt = 0;
  logic        mon_en    = 1'b0;
  logic [24:0] sb_q[$];
  logic [24:0] mon_prev;
  logic [24:0] mon_cur;
  logic [24:0] mon_exp;

  // {field, prog, modulee, data_2, start}
  function automatic logic [24:0] snap_now();
    return {bus.field, bus.prog, bus.modulee, bus.data_2, bus.start};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every change of the output bundle must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (bus.start === 1'b1) start_cnt++;
      if (mon_en) begin
        mon_cur = snap_now();
        if (mon_cur !== mon_prev) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_change: got %0h expected %0h", mon_cur, mon_prev);
          end else begin
            mon_exp = sb_q.pop_front();
            chk("scoreboard", mon_cur, mon_exp);
          end
          mon_prev = mon_cur;
        end
      end
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       bus.btn_c = v;
      1:       bus.btn_u = v;
      default: bus.btn_d = v;
    endcase
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk({"drain_", name}, sb_q.size(), 0);
  endtask

  // One full press (10 cycles high, 10 low) with the expected result.
  task automatic press(input int b, input logic [2:0] ef, input logic [2:0] ep,
                       input logic [1:0] em, input logic [15:0] ed,
                       input bit chg, input bit st, input string name);
    if (st) begin
      sb_q.push_back({ef, ep, em, ed, 1'b1});
      sb_q.push_back({ef, ep, em, ed, 1'b0});
    end else if (chg) begin
      sb_q.push_back({ef, ep, em, ed, 1'b0});
    end
    @(posedge clk); #1;
    set_btn(b, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    set_btn(b, 1'b0);
    repeat (10) @(posedge clk);
    wait_drain(name);
    #1;
    chk(name, snap_now(), {ef, ep, em, ed, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.btn_c = 1'b0;
    bus.btn_u = 1'b0;
    bus.btn_d = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", snap_now(), 25'd0);
    rst = 1'b0;
    mon_prev = snap_now();
    mon_en   = 1'b1;

    // 1. glitch shorter than DB_CYCLES
    @(posedge clk); #1;
    bus.btn_u = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.btn_u = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_no_press", snap_now(), 25'd0);

    // 2. prog 1..7 then wrap to 0
    for (int i = 1; i <= 8; i++) begin
      press(1, 3'd0, 3'(i % 8), 2'd0, 16'h0000, 1'b1, 1'b0, "prog_up");
    end

    // 3. module field, decrement wraps 0 -> 3
    press(0, 3'd1, 3'd0, 2'd0, 16'h0000, 1'b1, 1'b0, "c_to_mod");
    press(2, 3'd1, 3'd0, 2'd3, 16'h0000, 1'b1, 1'b0, "mod_dn_wrap");

    // 4. nibble 2 edits, then loop round to nibble 0
    press(0, 3'd2, 3'd0, 2'd3, 16'h0000, 1'b1, 1'b0, "c_to_d0");
    press(0, 3'd3, 3'd0, 2'd3, 16'h0000, 1'b1, 1'b0, "c_to_d1");
    press(0, 3'd4, 3'd0, 2'd3, 16'h0000, 1'b1, 1'b0, "c_to_d2");
    for (int i = 1; i <= 5; i++) begin
      press(1, 3'd4, 3'd0, 2'd3, 16'(i) << 8, 1'b1, 1'b0, "d2_up");
    end
    press(0, 3'd5, 3'd0, 2'd3, 16'h0500, 1'b1, 1'b0, "c_to_d3");
    press(0, 3'd6, 3'd0, 2'd3, 16'h0500, 1'b1, 1'b1, "c_to_run");
    press(0, 3'd0, 3'd0, 2'd3, 16'h0500, 1'b1, 1'b0, "run_to_prog");
    press(0, 3'd1, 3'd0, 2'd3, 16'h0500, 1'b1, 1'b0, "c_to_mod2");
    press(0, 3'd2, 3'd0, 2'd3, 16'h0500, 1'b1, 1'b0, "c_to_d0b");
    press(2, 3'd2, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "d0_dn_wrap");

    // 5. commit, frozen values in S_RUN, retained on return
    press(0, 3'd3, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "c_to_d1b");
    press(0, 3'd4, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "c_to_d2b");
    press(0, 3'd5, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "c_to_d3b");
    press(0, 3'd6, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b1, "commit");
    press(1, 3'd6, 3'd0, 2'd3, 16'h050F, 1'b0, 1'b0, "run_up_ignored");
    press(2, 3'd6, 3'd0, 2'd3, 16'h050F, 1'b0, 1'b0, "run_dn_ignored");
    press(0, 3'd0, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "run_retain");
    chk("start_pulses", start_cnt, 2);

    // 6. async reset mid-debounce in S_D1
    press(0, 3'd1, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "c_to_mod3");
    press(0, 3'd2, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "c_to_d0c");
    press(0, 3'd3, 3'd0, 2'd3, 16'h050F, 1'b1, 1'b0, "c_to_d1c");
    sb_q.push_back(25'd0);
    @(posedge clk); #1;
    bus.btn_u = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_now", snap_now(), 25'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.btn_u = 1'b0;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    wait_drain("reset");
    #1;
    chk("after_reset", snap_now(), 25'd0);
    chk("no_start_after_reset", start_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
